// File: rtl/matrix_mem_pkg.sv
// matrix_mem_pkg: shared widths, burst length and loader state encoding.
package matrix_mem_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_MATRIX_ELEMS = 4;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;
endpackage

// File: rtl/matrix_mem_array.sv
// matrix_mem_array: register-file store with one write port and a registered read port.
// READ_BYPASS_EN makes a same-address write visible on the read port immediately (write-first).
module matrix_mem_array
  import matrix_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef READ_BYPASS_EN
  assign rdata_d = (we_i && waddr_i == raddr_i) ? wdata_i : mem_q[raddr_i];
`else
  assign rdata_d = mem_q[raddr_i];
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_q <= rdata_d;
    end
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/matrix_memory_loader.sv
// matrix_memory_loader: matrix store serving calculator reads, filled by a valid/ready burst loader.
// Optional macro READ_BYPASS_EN selects write-first forwarding in the store.
module matrix_memory_loader
  import matrix_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int MATRIX_ELEMS = DEF_MATRIX_ELEMS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_busy,
  output logic              load_done
);
  localparam int CNT_W = (MATRIX_ELEMS > 1) ? $clog2(MATRIX_ELEMS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MATRIX_ELEMS - 1);
  state_e            state_q;
  logic [ADDR_W-1:0] wptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              ready_q, busy_q, done_q;
  logic              beat;
  assign beat = load_valid && ready_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (load_start) begin
          state_q <= LOAD;
          wptr_q  <= load_base;
          count_q <= '0;
          ready_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        LOAD: if (beat) begin
          wptr_q  <= wptr_q + 1'b1;
          count_q <= count_q + 1'b1;
          if (count_q == LAST) begin
            state_q <= DONE;
            ready_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
  matrix_mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
    .clk    (clk),
    .reset  (reset),
    .we_i   (beat),
    .waddr_i(wptr_q),
    .wdata_i(load_data),
    .raddr_i(address),
    .rdata_o(data_out)
  );
  assign load_ready = ready_q;
  assign load_busy  = busy_q;
  assign load_done  = done_q;
endmodule

// File: tb/tb_matrix_memory_loader.sv
// tb_matrix_memory_loader: directed plan plus random traffic against a burst-level reference model.
module tb_matrix_memory_loader;
  logic       clk = 0;
  logic       reset = 1;
  logic [3:0] address = 0;
  logic [7:0] data_out;
  logic       load_start = 0;
  logic [3:0] load_base = 0;
  logic       load_valid = 0;
  logic [7:0] load_data = 0;
  logic       load_ready, load_busy, load_done;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  matrix_memory_loader dut (
    .clk(clk), .reset(reset), .address(address), .data_out(data_out),
    .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .load_busy(load_busy),
    .load_done(load_done)
  );
  // reference: a burst is "open" with some beats left, followed by a one-cycle done phase
  logic [7:0] mem_m [16];
  logic [7:0] exp_dout;
  logic [3:0] m_ptr;
  int         m_left;
  logic       m_open, m_done, m_live;
  initial m_live = 0;
  always @(posedge clk) begin
    m_live <= 1;
    if (reset) begin
      foreach (mem_m[i]) mem_m[i] <= 8'h00;
      exp_dout <= 8'h00;
      m_open <= 0;
      m_done <= 0;
      m_left <= 0;
      m_ptr <= 0;
    end else begin
      exp_dout <= mem_m[address];
`ifdef READ_BYPASS_EN
      if (m_open && load_valid && m_ptr == address) exp_dout <= load_data;
`endif
      m_done <= 0;
      if (!m_open && !m_done && load_start) begin
        m_open <= 1;
        m_ptr <= load_base;
        m_left <= 4;
      end else if (m_open && load_valid) begin
        mem_m[m_ptr] <= load_data;
        m_ptr <= m_ptr + 4'd1;
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_open <= 0;
          m_done <= 1;
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (m_live) begin
    chk("data_out", 32'(data_out), 32'(exp_dout));
    chk("load_ready", 32'(load_ready), 32'(m_open));
    chk("load_busy", 32'(load_busy), 32'(m_open | m_done));
    chk("load_done", 32'(load_done), 32'(m_done));
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [3:0] base);
    load_start = 1;
    load_base = base;
    tick();
    load_start = 0;
  endtask
  task automatic beat(input logic [7:0] d);
    load_valid = 1;
    load_data = d;
    tick();
    load_valid = 0;
  endtask
  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string name);
    address = a;
    tick();
    chk(name, 32'(data_out), 32'(exp));
  endtask
  logic [7:0] b9 [4];
  logic [7:0] b14 [4];
  logic [7:0] gd [4];
  int pat [7];
  int k;
  initial begin
    b9 = '{8'h30, 8'h05, 8'h02, 8'h04};
    b14 = '{8'h11, 8'h22, 8'h33, 8'h44};
    pat = '{1, 0, 0, 1, 1, 0, 1};
    repeat (2) tick();
    chk("reset_ready", 32'(load_ready), 0);
    chk("reset_done", 32'(load_done), 0);
    reset = 0;
    for (int a = 0; a < 16; a++) rd(4'(a), 8'h00, "reset_read");
    start(4'd9);
    chk("ready_after_start", 32'(load_ready), 1);
    for (int i = 0; i < 4; i++) begin
      chk("ready_during_burst", 32'(load_ready), 1);
      beat(b9[i]);
    end
    chk("done_after_4th", 32'(load_done), 1);
    chk("ready_in_done", 32'(load_ready), 0);
    chk("model_word9", 32'(mem_m[9]), 32'h30);
    tick();
    chk("done_one_cycle", 32'(load_done), 0);
    rd(4'd9, 8'h30, "read9");
    rd(4'd12, 8'h04, "read12");
    start(4'd14);
    for (int i = 0; i < 4; i++) beat(b14[i]);
    tick();
    rd(4'd14, 8'h11, "wrap14");
    rd(4'd15, 8'h22, "wrap15");
    rd(4'd0, 8'h33, "wrap0");
    rd(4'd1, 8'h44, "wrap1");
    chk("model_wrap1", 32'(mem_m[1]), 32'h44);
    start(4'd3);
    k = 0;
    for (int i = 0; i < 7; i++) begin
      load_data = 8'($urandom);
      if (pat[i] == 1) begin
        gd[k] = load_data;
        k++;
      end
      load_valid = (pat[i] == 1);
      load_start = (i == 2);
      load_base = 4'd7;
      tick();
    end
    load_valid = 0;
    load_start = 0;
    chk("gapped_done", 32'(load_done), 1);
    tick();
    for (int i = 0; i < 4; i++) rd(4'(3 + i), gd[i], "gapped_word");
    rd(4'd7, 8'h00, "no_restart_word7");
    start(4'd10);
    address = 4'd10;
    beat(8'h55);
`ifdef READ_BYPASS_EN
    chk("same_addr_read", 32'(data_out), 32'h55);
`else
    chk("same_addr_read", 32'(data_out), 32'h05);
`endif
    tick();
    chk("next_read", 32'(data_out), 32'h55);
    for (int i = 0; i < 3; i++) beat(8'($urandom));
    tick();
    start(4'd2);
    beat(8'hA1);
    beat(8'hA2);
    reset = 1;
    tick();
    reset = 0;
    chk("abort_done", 32'(load_done), 0);
    chk("abort_ready", 32'(load_ready), 0);
    chk("abort_busy", 32'(load_busy), 0);
    for (int a = 0; a < 16; a++) rd(4'(a), 8'h00, "abort_read");
    start(4'd5);
    for (int i = 0; i < 4; i++) beat(8'(i + 1));
    start(4'd0);
    tick();
    start(4'd8);
    chk("back_to_back_ready", 32'(load_ready), 1);
    for (int i = 0; i < 3000; i++) begin
      address = 4'($urandom);
      load_start = ($urandom_range(0, 7) == 0);
      load_base = 4'($urandom);
      load_valid = ($urandom_range(0, 2) != 0);
      load_data = 8'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 0;
    load_valid = 0;
    load_start = 0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/matrix_memory_loader.md
Name: matrix_memory_loader

Overview:
- Memory responder on the far side of the determinant calculator's memory read interface.
- Holds a 16-word x 8-bit matrix store. Serves the calculator's address requests with registered 1-cycle read data.
- Accepts a streamed 2x2 matrix (4 elements) over a valid/ready load port, written starting at a chosen base address.
- Sits between the testbench/host loader and determinant_calculator's address_to_memory / data_in pins.

Parameters:
- DATA_W, 8, element width in bits; matches calculator data_in.
- ADDR_W, 4, address width; depth = 2**ADDR_W = 16 words.
- MATRIX_ELEMS, 4, elements per load burst (2x2 matrix, row-major).

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- address  input  ADDR_W  read address; driven by the calculator's address_to_memory.
- data_out  output  DATA_W  registered read data; drives the calculator's data_in.
- load_start  input  1  pulse that begins a load burst; sampled only in IDLE.
- load_base  input  ADDR_W  base address for the burst; latched together with load_start.
- load_valid  input  1  load_data is valid this cycle.
- load_data  input  DATA_W  element to write.
- load_ready  output  1  loader accepts a beat this cycle.
- load_busy  output  1  high in LOAD and DONE.
- load_done  output  1  one-cycle pulse after the last element is written.

Behaviour:
- Reset (synchronous, active-high, wins over every other input):
  - all 16 words = 0; data_out = 0; load_ready = 0; load_busy = 0; load_done = 0.
  - state = IDLE; write pointer = 0; element count = 0.
- Read port:
  - every non-reset cycle, data_out <= mem[address]. Latency is exactly 1 cycle; no enable.
  - Reads are legal in every state, including during a load.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: load_ready = 0. If load_start = 1: latch wptr <= load_base, count <= 0, go to LOAD.
  - LOAD: load_ready = 1, load_busy = 1.
    - A beat is accepted when load_valid && load_ready: mem[wptr] <= load_data; wptr <= wptr + 1 (mod 16); count <= count + 1.
    - When the accepted beat has count == MATRIX_ELEMS-1, go to DONE.
    - load_valid = 0 simply stalls; there is no timeout.
  - DONE: load_ready = 0, load_busy = 1, load_done = 1 for exactly one cycle, then go to IDLE.
- load_start is ignored outside IDLE; a second start during LOAD does not restart or re-latch the base.
- load_valid while load_ready = 0 is ignored: no write, no count change.
- Address wrap-around: base 14 writes words 14, 15, 0, 1.
- Simultaneous read and write to the same address (default): data_out returns the OLD word (read-before-write). The new value is visible on the following read.
- Reset mid-burst: the burst is aborted and all memory is cleared; no load_done is produced.
- Back-to-back bursts: load_start may be asserted in the IDLE cycle that follows DONE, giving a 1-cycle minimum gap.

Optional Feature:
- Macro: READ_BYPASS_EN.
- Defined: a same-cycle write to the address being read forwards load_data to data_out (write-first), so data_out = new data one cycle later.
- Undefined: read-before-write as described in Behaviour.
- No other behaviour changes.

Decomposition:
- Package matrix_mem_pkg holds: DATA_W, ADDR_W, MATRIX_ELEMS defaults, and the state enum {IDLE, LOAD, DONE}.
- One natural sub-module: matrix_mem_array.
  - 16x8 register file, synchronous clear on reset.
  - One write port and one registered read port; bypass logic under READ_BYPASS_EN.
- The top level holds the FSM, write pointer and element counter.

Test Plan:
- Reset, then read addresses 0..15 -> data_out = 0x00 for all, each one cycle after its address.
- load_start with base 9; beats 0x30, 0x05, 0x02, 0x04 with valid held high -> words 9..12 written; load_ready high for 4 cycles; load_done pulses once, 1 cycle after the 4th beat; reading address 9 gives 0x30 one cycle later.
- Base 14; beats 0x11, 0x22, 0x33, 0x44 -> mem[14] = 0x11, mem[15] = 0x22, mem[0] = 0x33, mem[1] = 0x44.
- Gapped load_valid (1,0,0,1,1,0,1) -> exactly 4 writes; count and wptr hold during gaps; load_start pulsed mid-burst has no effect.
- Read address 10 while 0x55 is written to 10 (old value 0x05) -> data_out = 0x05 by default, 0x55 with READ_BYPASS_EN; next read gives 0x55 in both builds.
- Assert reset after 2 beats -> no load_done; state IDLE; all words read 0x00; load_ready = 0.
